ex_muldiv_unit: RTL



---
 rtl/ex_muldiv_unit_if.sv | 31 +++
 rtl/ex_muldiv_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit_if.sv
// Bus between the EX stage and the iterative RV32M multiply/divide unit.
// The slave modport is the unit side. The master modport is the pipeline/driver side.
interface ex_muldiv_unit_if #(
    parameter int NB_DATA = 32
);
    logic               i_start;
    logic [2:0]         i_funct3;
    logic [1:0]         i_forward_a;
    logic [1:0]         i_forward_b;
    logic [NB_DATA-1:0] i_rs1_data;
    logic [NB_DATA-1:0] i_rs2_data;
    logic [NB_DATA-1:0] i_mem_result;
    logic [NB_DATA-1:0] i_wb_result;
    logic               i_flush;
    logic               o_stall;
    logic               o_busy;
    logic               o_done;
    logic [NB_DATA-1:0] o_result;

    modport slave (
        input  i_start, i_funct3, i_forward_a, i_forward_b,
        input  i_rs1_data, i_rs2_data, i_mem_result, i_wb_result, i_flush,
        output o_stall, o_busy, o_done, o_result
    );

    modport master (
        output i_start, i_funct3, i_forward_a, i_forward_b,
        output i_rs1_data, i_rs2_data, i_mem_result, i_wb_result, i_flush,
        input  o_stall, o_busy, o_done, o_result
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Operands are picked from the regfile or from forwarded MEM/WB values and captured at start.
// It then runs NB_DATA shift-add or restoring-divide steps and stalls the pipeline while busy.
// Optional macro MULDIV_FAST_MUL_EN: multiplies become a single-cycle combinational product.
module ex_muldiv_unit #(
    parameter int NB_DATA = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    ex_muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(NB_DATA) + 1;
    localparam int NW = 2 * NB_DATA;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic               qneg_q, qneg_d;   // product / quotient negate
    logic               rneg_q, rneg_d;   // remainder negate (dividend sign)
    logic [NW-1:0]      acc_q, acc_d;     // {high, low}: product, or {remainder, quotient}
    logic [NB_DATA-1:0] opb_q, opb_d;     // multiplicand / divisor magnitude
    logic [NB_DATA-1:0] res_q;

    logic [NB_DATA-1:0] op_a, op_b, mag_a, mag_b;
    logic               a_sgn, b_sgn, sa, sb, div_zero, div_ovf;
    logic [NB_DATA:0]   mul_sum, div_r, div_diff;
    logic [NW-1:0]      prod_fix;
    logic [NB_DATA-1:0] quo_fix, rem_fix, fin;

`ifdef MULDIV_FAST_MUL_EN
    logic [NW-1:0]      fa, fb, fprod;

    // Single-cycle product: sign-extending to full width keeps the low NW bits exact
    always_comb begin
        fa    = {{NB_DATA{a_sgn & op_a[NB_DATA-1]}}, op_a};
        fb    = {{NB_DATA{b_sgn & op_b[NB_DATA-1]}}, op_b};
        fprod = fa * fb;
    end
`endif

    // Forwarding mux; select 11 falls back to the regfile value
    always_comb begin
        case (bus.i_forward_a)
            2'b10:   op_a = bus.i_mem_result;
            2'b01:   op_a = bus.i_wb_result;
            default: op_a = bus.i_rs1_data;
        endcase
        case (bus.i_forward_b)
            2'b10:   op_b = bus.i_mem_result;
            2'b01:   op_b = bus.i_wb_result;
            default: op_b = bus.i_rs2_data;
        endcase
    end

    // Operand signedness, magnitudes and divide special cases, decoded from the incoming funct3
    always_comb begin
        a_sgn    = (bus.i_funct3 == 3'b001) || (bus.i_funct3 == 3'b010) ||
                   (bus.i_funct3 == 3'b100) || (bus.i_funct3 == 3'b110);
        b_sgn    = (bus.i_funct3 == 3'b001) || (bus.i_funct3 == 3'b100) ||
                   (bus.i_funct3 == 3'b110);
        sa       = a_sgn & op_a[NB_DATA-1];
        sb       = b_sgn & op_b[NB_DATA-1];
        mag_a    = sa ? -op_a : op_a;
        mag_b    = sb ? -op_b : op_b;
        div_zero = bus.i_funct3[2] && (op_b == '0);
        div_ovf  = bus.i_funct3[2] && !bus.i_funct3[0] &&
                   (op_a == {1'b1, {(NB_DATA-1){1'b0}}}) && (op_b == '1);
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_sum  = {1'b0, acc_q[NW-1:NB_DATA]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_r    = acc_q[NW-1:NB_DATA-1];
        div_diff = div_r - {1'b0, opb_q};
    end

    // Next-state logic: capture at start, step in RUN, single-cycle exit from DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    f3_d    = bus.i_funct3;
                    cnt_d   = '0;
                    opb_d   = mag_b;
                    qneg_d  = sa ^ sb;
                    rneg_d  = sa;
                    acc_d   = {{NB_DATA{1'b0}}, mag_a};
                    state_d = RUN;
                    // Special cases preload {remainder, quotient} so DONE needs no extra path
                    if (div_zero) begin
                        acc_d   = {op_a, {NB_DATA{1'b1}}};
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DONE;
                    end else if (div_ovf) begin
                        acc_d   = {{NB_DATA{1'b0}}, op_a};
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!bus.i_funct3[2]) begin
                        acc_d   = fprod;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                if (f3_q[2]) begin
                    if (!div_diff[NB_DATA])
                        acc_d = {div_diff[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
                    else
                        acc_d = {div_r[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[NB_DATA-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NB_DATA - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.i_flush) state_d = IDLE;
    end

    // Sign correction on the value entering DONE, so o_result is valid alongside o_done
    always_comb begin
        prod_fix = qneg_d ? -acc_d : acc_d;
        quo_fix  = qneg_d ? -acc_d[NB_DATA-1:0] : acc_d[NB_DATA-1:0];
        rem_fix  = rneg_d ? -acc_d[NW-1:NB_DATA] : acc_d[NW-1:NB_DATA];
        if (f3_d[2])
            fin = f3_d[1] ? rem_fix : quo_fix;
        else
            fin = (f3_d[1:0] == 2'b00) ? prod_fix[NB_DATA-1:0] : prod_fix[NW-1:NB_DATA];
    end

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            acc_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
        end
    end

    // Result register; only a completing operation updates it (flush forces IDLE, so it holds)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                res_q <= '0;
        else if (state_d == DONE) res_q <= fin;
    end

    assign bus.o_busy   = (state_q != IDLE);
    assign bus.o_done   = (state_q == DONE) && !bus.i_flush;
    assign bus.o_stall  = ((state_q == IDLE) && bus.i_start && !bus.i_flush && !i_rst) ||
                          (state_q == RUN);
    assign bus.o_result = res_q;
endmodule
